// File: rtl/hub75_fb_memctrl.sv
// HUB75 framebuffer memory controller: round-robin arbitration of row-engine clients onto one
// single-port memory, plus double/triple frame-buffer index management with drop accounting.
module hub75_fb_memctrl #(
  parameter int unsigned          N_CLIENTS = 2,
  parameter logic [N_CLIENTS-1:0] WR_MASK   = 'b01,
  parameter int unsigned          N_FRAMES  = 2,
  parameter int unsigned          ADDR_W    = 13,
  parameter int unsigned          DATA_W    = 16,
  parameter int unsigned          BUF_W     = $clog2(N_FRAMES)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_CLIENTS-1:0]          cli_req_i,
  output logic [N_CLIENTS-1:0]          cli_gnt_o,
  input  logic [N_CLIENTS-1:0]          cli_rel_i,
  input  logic [N_CLIENTS*ADDR_W-1:0]   cli_addr_i,
  input  logic [N_CLIENTS*DATA_W-1:0]   cli_wdata_i,
  input  logic [N_CLIENTS-1:0]          cli_wren_i,
  input  logic [N_CLIENTS-1:0]          cli_rden_i,
  output logic [DATA_W-1:0]             cli_rdata_o,
  output logic [N_CLIENTS-1:0]          cli_rvalid_o,
  output logic [BUF_W+ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic                          mem_wren_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  input  logic                          frame_swap_i,
  input  logic                          frame_sync_i,
  output logic [BUF_W-1:0]              front_idx_o,
  output logic [BUF_W-1:0]              back_idx_o,
  output logic                          swap_pending_o,
  output logic [15:0]                   drop_cnt_o
);

  localparam int unsigned IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} arb_state_e;

  arb_state_e              state_q;
  logic [N_CLIENTS-1:0]    gnt_q;
  logic [N_CLIENTS-1:0]    rvalid_q;
  logic [IDX_W-1:0]        gidx_q;
  logic [IDX_W-1:0]        rr_q;
  logic [BUF_W-1:0]        buf_q;

  logic [BUF_W-1:0]        front_q, front_d;
  logic [BUF_W-1:0]        back_q, back_d;
  logic [BUF_W-1:0]        ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic [15:0]             drop_q, drop_d;
  logic                    drop_inc;

  logic                    found;
  logic [IDX_W-1:0]        pick;
  logic [IDX_W-1:0]        cand;
  logic [IDX_W-1:0]        rr_next;

  // First requester at or after the round-robin pointer, wrapping modulo N_CLIENTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < int'(N_CLIENTS); i++) begin
      cand = IDX_W'((32'(rr_q) + 32'(i)) % N_CLIENTS);
      if (!found && cli_req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    if (32'(gidx_q) == N_CLIENTS - 1) rr_next = '0;
    else                              rr_next = gidx_q + IDX_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gidx_q   <= '0;
      rr_q     <= '0;
      buf_q    <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= cli_rden_i & gnt_q;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            gnt_q   <= N_CLIENTS'(1) << pick;
            gidx_q  <= pick;
            // Buffer is frozen for the whole tenure; later swaps only affect later grants.
            buf_q   <= WR_MASK[pick] ? back_q : front_q;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cli_rel_i[gidx_q]) begin
            gnt_q   <= '0;
            rr_q    <= rr_next;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_addr_o   = {buf_q, cli_addr_i[32'(gidx_q)*ADDR_W +: ADDR_W]};
    mem_wdata_o  = cli_wdata_i[32'(gidx_q)*DATA_W +: DATA_W];
    mem_wren_o   = gnt_q[gidx_q] & cli_wren_i[gidx_q] & WR_MASK[gidx_q];
    cli_gnt_o    = gnt_q;
    cli_rvalid_o = rvalid_q;
    cli_rdata_o  = mem_rdata_i;
  end

  always_comb begin
    front_d  = front_q;
    back_d   = back_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    drop_inc = 1'b0;
    if (N_FRAMES == 3) begin
      // An unconsumed ready frame replaced by a new one is a drop.
      drop_inc = frame_swap_i & valid_q;
      if (frame_swap_i && frame_sync_i) begin
        front_d = back_q;
        back_d  = ready_q;
        ready_d = front_q;
        valid_d = 1'b0;
      end else if (frame_swap_i) begin
        back_d  = ready_q;
        ready_d = back_q;
        valid_d = 1'b1;
      end else if (frame_sync_i && valid_q) begin
        front_d = ready_q;
        ready_d = front_q;
        valid_d = 1'b0;
      end
    end else begin
      drop_inc = frame_swap_i & valid_q & ~frame_sync_i;
      if (frame_sync_i && (valid_q || frame_swap_i)) begin
        front_d = back_q;
        back_d  = front_q;
        valid_d = 1'b0;
      end else if (frame_swap_i) begin
        valid_d = 1'b1;
      end
    end
    drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      front_q <= BUF_W'(0);
      back_q  <= BUF_W'(1);
      ready_q <= BUF_W'(2 % N_FRAMES);
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      front_q <= front_d;
      back_q  <= back_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign front_idx_o    = front_q;
  assign back_idx_o     = back_q;
  assign swap_pending_o = valid_q;
  assign drop_cnt_o     = drop_q;

endmodule
